// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with multi-cycle multiply and restoring divide.
module hilo_muldiv_unit #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MFHI  = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        qs_q, qs_d;
  logic        rs_q, rs_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbzp_q, dbzp_d;

  logic        accept, is_mul, is_div, div_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] r_shift, diff;

  assign accept     = start && (state_q == S_IDLE);
  assign is_mul     = (alu_control == OP_MULT || alu_control == OP_MULTU) && hi_we && lo_we;
  assign is_div     = (alu_control == OP_DIV || alu_control == OP_DIVU) && hi_we && lo_we;
  assign div_signed = (alu_control == OP_DIV);

  // Low 64 bits of the product of extended operands equal the signed/unsigned product.
  assign ext_a = {(sgn_q ? {32{a_q[31]}} : 32'h0), a_q};
  assign ext_b = {(sgn_q ? {32{b_q[31]}} : 32'h0), b_q};
  assign prod  = ext_a * ext_b;

  assign r_shift = {rem_q, a_q[31]};
  assign diff    = r_shift - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbzp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbzp_q  <= dbzp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) state_d = S_MUL;
        else if (accept && is_div) state_d = (operand_b == 32'h0) ? S_FIX : S_DIV;
      end
      S_MUL:   if (cnt_q == 6'd0) state_d = S_IDLE;
      S_DIV:   if (cnt_q == 6'd31) state_d = S_FIX;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    sgn_d  = sgn_q;
    qs_d   = qs_q;
    rs_d   = rs_q;
    dbz_d  = dbz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dbzp_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          a_d   = operand_a;
          b_d   = operand_b;
          sgn_d = (alu_control == OP_MULT);
          cnt_d = 6'(MUL_LATENCY - 1);
        end else if (accept && is_div) begin
          cnt_d = '0;
          if (operand_b == 32'h0) begin
            dbz_d = 1'b1;
            rem_d = operand_a;
          end else begin
            dbz_d = 1'b0;
            rem_d = '0;
            a_d   = (div_signed && operand_a[31]) ? -operand_a : operand_a;
            b_d   = (div_signed && operand_b[31]) ? -operand_b : operand_b;
            qs_d  = div_signed && (operand_a[31] ^ operand_b[31]);
            rs_d  = div_signed && operand_a[31];
          end
        end else if (accept) begin
          if (alu_control == OP_MTHI && hi_we) hi_d = operand_a;
          if (alu_control == OP_MTLO && lo_we) lo_d = operand_a;
        end
      end
      S_MUL: begin
        if (cnt_q == 6'd0) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        // a_q shifts out dividend bits at the top and collects quotient bits at the bottom.
        rem_d = diff[32] ? r_shift[31:0] : diff[31:0];
        a_d   = {a_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
      end
      default: begin
        done_d = 1'b1;
        if (dbz_q) begin
          hi_d   = rem_q;
          lo_d   = 32'hFFFF_FFFF;
          dbzp_d = 1'b1;
        end else begin
          lo_d = qs_q ? -a_q : a_q;
          hi_d = rs_q ? -rem_q : rem_q;
        end
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    stall       = start && busy;
    done        = done_q;
    div_by_zero = dbzp_q;
    hi          = hi_q;
    lo          = lo_q;
    if (alu_control == OP_MFHI)      mf_data = hi_q;
    else if (alu_control == OP_MFLO) mf_data = lo_q;
    else                             mf_data = 32'h0;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - Self-checking bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;

  localparam int LAT = 2;
  localparam logic [4:0] C_MULT  = 5'b10000;
  localparam logic [4:0] C_MULTU = 5'b10001;
  localparam logic [4:0] C_DIV   = 5'b10010;
  localparam logic [4:0] C_DIVU  = 5'b10011;
  localparam logic [4:0] C_MTLO  = 5'b10101;
  localparam logic [4:0] C_MTHI  = 5'b10110;
  localparam logic [4:0] C_MFLO  = 5'b11000;
  localparam logic [4:0] C_MFHI  = 5'b11001;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [4:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo, mf_data;

  int n_chk = 0;
  int n_fail = 0;

  hilo_muldiv_unit #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .hi_we(hi_we), .lo_we(lo_we), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a, b, e_hi, e_lo;
    logic        e_dbz;
    int          e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference from plain 64-bit arithmetic; SV division truncates toward zero like the ISA.
  function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] m_hi, output logic [31:0] m_lo,
                                output logic m_dbz, output int m_lat);
    longint      q, r, sp;
    logic [63:0] up;
    m_dbz = 1'b0;
    if (code == C_MULT || code == C_MULTU) begin
      if (code == C_MULT) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
      end else begin
        up = {32'h0, a} * {32'h0, b};
      end
      m_hi = up[63:32];
      m_lo = up[31:0];
      m_lat = LAT;
    end else if (b == 32'h0) begin
      m_hi = a;
      m_lo = 32'hFFFF_FFFF;
      m_dbz = 1'b1;
      m_lat = 1;
    end else begin
      if (code == C_DIV) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
      end else begin
        q = longint'({32'h0, a}) / longint'({32'h0, b});
        r = longint'({32'h0, a}) % longint'({32'h0, b});
      end
      m_lo = 32'(q);
      m_hi = 32'(r);
      m_lat = 33;
    end
  endfunction

  task automatic do_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] o_hi, output logic [31:0] o_lo, output logic o_dbz,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; alu_control = code; hi_we = 1'b1; lo_we = 1'b1;
    operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; alu_control = 5'b0;
    operand_a = $urandom; operand_b = $urandom;
    lat = 0; bcnt = 0;
    if (busy) bcnt++;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy && !done) bcnt++;
    end
    o_hi = hi; o_lo = lo; o_dbz = div_by_zero;
  endtask

  task automatic check_op(input string name, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dbz, input int e_lat);
    logic [31:0] g_hi, g_lo;
    logic        g_dbz;
    int          g_lat, g_b;
    do_op(code, a, b, g_hi, g_lo, g_dbz, g_lat, g_b);
    chk({name, " latency"}, 64'(g_lat), 64'(e_lat));
    chk({name, " busy_cycles"}, 64'(g_b), 64'(e_lat));
    chk({name, " hi"}, 64'(g_hi), 64'(e_hi));
    chk({name, " lo"}, 64'(g_lo), 64'(e_lo));
    chk({name, " div_by_zero"}, 64'(g_dbz), 64'(e_dbz));
    chk({name, " busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic mt(input logic [4:0] code, input logic [31:0] v, input logic he, input logic le);
    @(negedge clk);
    start = 1'b1; alu_control = code; hi_we = he; lo_we = le; operand_a = v; operand_b = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    logic [31:0] m_hi, m_lo;
    logic        m_dbz;
    logic [4:0]  code;
    logic [31:0] a, b;
    int          m_lat, cyc, scnt, dcnt;

    vecs[0]  = '{C_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, LAT};
    vecs[1]  = '{C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT};
    vecs[2]  = '{C_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{C_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0, 33};
    vecs[4]  = '{C_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[5]  = '{C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 33};
    vecs[6]  = '{C_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[7]  = '{C_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0, LAT};
    vecs[8]  = '{C_MULTU, 32'h8000_0000, 32'd2,        32'd1,         32'h0,         1'b0, LAT};
    vecs[9]  = '{C_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 33};
    vecs[10] = '{C_DIVU,  32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF, 1'b0, 33};

    reset = 1'b1; start = 1'b0; alu_control = 5'b0; hi_we = 1'b0; lo_we = 1'b0;
    operand_a = 32'h0; operand_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Moves to/from HI/LO, including enables off.
    mt(C_MTHI, 32'hCAFE_0001, 1'b1, 1'b0);
    chk("mthi hi", 64'(hi), 64'hCAFE_0001);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    mt(C_MTLO, 32'hBEEF_0002, 1'b0, 1'b1);
    chk("mtlo lo", 64'(lo), 64'hBEEF_0002);
    mt(C_MTHI, 32'h1111_1111, 1'b0, 1'b0);
    chk("mthi no_we hi", 64'(hi), 64'hCAFE_0001);
    alu_control = C_MFHI; #1;
    chk("mfhi data", 64'(mf_data), 64'hCAFE_0001);
    alu_control = C_MFLO; #1;
    chk("mflo data", 64'(mf_data), 64'hBEEF_0002);
    alu_control = C_MULT; #1;
    chk("mf other code", 64'(mf_data), 64'd0);

    for (int i = 0; i < 11; i++)
      check_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
               vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_dbz, vecs[i].e_lat);

    // Done/div_by_zero last exactly one cycle.
    check_op("dbz_pulse", C_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1);
    @(posedge clk); #1;
    chk("dbz_pulse done_fall", 64'(done), 64'd0);
    chk("dbz_pulse dbz_fall", 64'(div_by_zero), 64'd0);

    // MFHI in the done cycle of a MULTU.
    check_op("multu_mfhi", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, LAT);
    start = 1'b1; alu_control = C_MFHI; #1;
    chk("multu_mfhi stall", 64'(stall), 64'd0);
    chk("multu_mfhi data", 64'(mf_data), 64'hFFFF_FFFE);
    @(negedge clk);
    start = 1'b0;

    // MFLO held while a divide runs: stall until done, then quotient visible.
    @(negedge clk);
    start = 1'b1; alu_control = C_DIVU; hi_we = 1'b1; lo_we = 1'b1;
    operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; operand_a = 32'd1; operand_b = 32'd1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; alu_control = C_MFLO; #1;
    scnt = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (stall) scnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("mflo_wait stall_cycles", 64'(scnt), 64'd29);
    chk("mflo_wait stall_done", 64'(stall), 64'd0);
    chk("mflo_wait data", 64'(mf_data), 64'd14);
    chk("mflo_wait hi", 64'(hi), 64'd2);
    @(negedge clk);
    start = 1'b0;

    // Reset mid-divide aborts with no write.
    mt(C_MTHI, 32'h1234, 1'b1, 1'b0);
    mt(C_MTLO, 32'h1234, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; alu_control = C_DIV; hi_we = 1'b1; lo_we = 1'b1;
    operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort no_done", 64'(dcnt), 64'd0);
    mt(C_MTLO, 32'hA5, 1'b0, 1'b1);
    chk("abort mtlo", 64'(lo), 64'hA5);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       code = C_MULT;
        1:       code = C_MULTU;
        2:       code = C_DIV;
        default: code = C_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      model(code, a, b, m_hi, m_lo, m_dbz, m_lat);
      check_op($sformatf("rand%0d code=%b a=%h b=%h", i, code, a, b), code, a, b,
               m_hi, m_lo, m_dbz, m_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
